// File: rtl/accel_pkg.sv
// Shared definitions for the block-cipher accelerator DMA paths.
//   fetch_state_t : states of the source-buffer fetch engine
//   BLK_W/WORD_W  : cipher block width and Avalon data width
//   blk_t         : one cipher block as stored in the DMA FIFOs
package accel_pkg;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DRAIN, FINISH} fetch_state_t;

    localparam int BLK_W  = 64;
    localparam int WORD_W = 32;

    typedef logic [BLK_W-1:0] blk_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, shared by the DMA fetch and
// write-back paths.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset (empties FIFO)
//   push, push_data    : write request and data; ignored when full unless a
//                        pop frees the slot in the same cycle
//   pop                : read request; ignored when empty
//   full, empty        : occupancy flags
//   head               : oldest entry, meaningful while !empty
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; emptiness is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/avalon_dma_fetch.sv
// Avalon-MM read initiator that fetches the cipher source buffer.
// Each 64-bit block is read as two 32-bit words (low word first), assembled,
// buffered in a sync_fifo and offered to the cipher core on a valid/ready
// stream.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   start, src_addr, num_blk: launch pulse, byte start address, block count
//   busy, done              : transfer in progress / one-cycle completion
//   avm_*                   : Avalon-MM read master (zero-latency reads)
//   blk_valid/data/ready    : block stream towards the cipher core
module avalon_dma_fetch
    import accel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       num_blk,
    output logic              busy,
    output logic              done,
    output logic              avm_read,
    output logic [ADDR_W-1:0] avm_address,
    input  logic              avm_waitrequest,
    input  logic [WORD_W-1:0] avm_readdata,
    output logic              blk_valid,
    output blk_t              blk_data,
    input  logic              blk_ready
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       cnt_q;
    logic [WORD_W-1:0] lo_q;
    logic              word_acc;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              unused_addr_bits;

    // Word addresses only; the byte offset is dropped on load.
    assign unused_addr_bits = ^src_addr[1:0];

    assign word_acc    = avm_read && !avm_waitrequest;
    assign avm_address = addr_q;
    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    assign blk_valid   = !fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        avm_read  = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (num_blk != 32'd0) ? RD_LO : FINISH;
            end
            RD_LO: begin
                // A block is only started when its FIFO slot is guaranteed,
                // which lets RD_HI push unconditionally.
                avm_read = !fifo_full;
                if (word_acc) state_nxt = RD_HI;
            end
            RD_HI: begin
                avm_read = 1'b1;
                if (word_acc) begin
                    push      = 1'b1;
                    state_nxt = (cnt_q == 32'd1) ? DRAIN : RD_LO;
                end
            end
            DRAIN: begin
                if (fifo_empty) state_nxt = FINISH;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (state == IDLE && start) begin
                addr_q <= {src_addr[ADDR_W-1:2], 2'b00};
                cnt_q  <= num_blk;
            end else if (word_acc) begin
                // Modulo 2^ADDR_W: wraps past the top of the address space.
                addr_q <= addr_q + ADDR_W'(4);
                if (state == RD_HI) cnt_q <= cnt_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (word_acc && state == RD_LO) lo_q <= avm_readdata;
    end

    sync_fifo #(
        .WIDTH (BLK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({avm_readdata, lo_q}),
        .pop       (blk_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (blk_data)
    );

endmodule

// File: tb/tb_avalon_dma_fetch.sv
module tb_avalon_dma_fetch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] num_blk;
    logic        busy;
    logic        done;
    logic        avm_read;
    logic [31:0] avm_address;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        blk_valid;
    logic [63:0] blk_data;
    logic        blk_ready;

    avalon_dma_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .src_addr        (src_addr),
        .num_blk         (num_blk),
        .busy            (busy),
        .done            (done),
        .avm_read        (avm_read),
        .avm_address     (avm_address),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .blk_valid       (blk_valid),
        .blk_data        (blk_data),
        .blk_ready       (blk_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: two fixed words from the test plan, hash elsewhere.
    logic [31:0] salt = 32'h0;
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
        if (a == 32'h0000_1000) return 32'h1111_1111;
        if (a == 32'h0000_1004) return 32'h2222_2222;
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    always_comb avm_readdata = mem_word(avm_address, salt);

    // Stimulus drivers: 0 = idle level, 1 = random, 2 = scripted by main.
    int wait_mode  = 0;
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        if (wait_mode == 0)      avm_waitrequest = 1'b0;
        else if (wait_mode == 1) avm_waitrequest = ($urandom_range(0, 3) == 0);
        if (ready_mode == 0)      blk_ready = 1'b1;
        else if (ready_mode == 1) blk_ready = ($urandom_range(0, 2) != 0);
    end

    // Reference model: expected read addresses and blocks, FIFO occupancy.
    logic [31:0] exp_addr[$];
    logic [63:0] exp_blk[$];
    int          occ, n_rd, n_push, n_done;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic        mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            int pu, po;
            pu = 0;
            po = 0;
            chk("blk_valid", blk_valid, occ != 0);
            if (occ == DEPTH) chk("rd_when_full", avm_read, 1'b0);
            if (prev_stall) begin
                chk("hold_read", avm_read, 1'b1);
                chk("hold_addr", avm_address, prev_addr);
            end
            if (avm_read && !avm_waitrequest) begin
                if (exp_addr.size() == 0) chk("extra_read", avm_address, 64'hDEAD);
                else                      chk("rd_addr", avm_address, exp_addr.pop_front());
                n_rd++;
                if (n_rd % 2 == 0) begin
                    n_push++;
                    pu = 1;
                end
            end
            if (blk_valid && blk_ready) begin
                if (exp_blk.size() == 0) chk("extra_blk", blk_data, 64'hDEAD);
                else                     chk("blk_data", blk_data, exp_blk.pop_front());
                po = 1;
            end
            if (done) begin
                n_done++;
                chk("empty_at_done", blk_valid, 1'b0);
            end
            occ        = occ + pu - po;
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
        end
    end

    task automatic setup(input logic [31:0] base, input logic [31:0] n);
        logic [31:0] a;
        a = {base[31:2], 2'b00};
        exp_addr.delete();
        exp_blk.delete();
        for (int i = 0; i < 2 * int'(n); i++) exp_addr.push_back(a + 32'(4 * i));
        for (int k = 0; k < int'(n); k++)
            exp_blk.push_back({mem_word(a + 32'(8 * k + 4), salt), mem_word(a + 32'(8 * k), salt)});
        occ = 0; n_rd = 0; n_push = 0; n_done = 0; prev_stall = 1'b0; prev_addr = '0;
        src_addr = base;
        num_blk  = n;
        mon_en   = 1'b1;
    endtask

    // Leaves the caller #1 after the edge that accepted start.
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_xfer(input string tag);
        int cyc;
        cyc = 0;
        while (n_done == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (n_done == 0) chk({tag, "_done_timeout"}, 0, 1);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_done_once"}, n_done, 1);
        chk({tag, "_reads_left"}, exp_addr.size(), 0);
        chk({tag, "_blks_left"}, exp_blk.size(), 0);
        mon_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        reset_n = 1'b0; start = 1'b0; src_addr = '0; num_blk = '0;
        avm_waitrequest = 1'b0; blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_read", avm_read, 1'b0);
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_valid", blk_valid, 1'b0);
        reset_n = 1'b1;

        // Single block, no wait states, latency and data.
        setup(32'h1000, 1);
        pulse_start();
        k = 1;
        while (!blk_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t1_latency", k, 3);
        chk("t1_data", blk_data, 64'h2222_2222_1111_1111);
        finish_xfer("t1");

        // Zero blocks: FINISH directly, no Avalon traffic.
        setup(32'h4000, 0);
        pulse_start();
        chk("t2_done", done, 1'b1);
        chk("t2_busy", busy, 1'b1);
        chk("t2_read", avm_read, 1'b0);
        @(posedge clk); #1;
        chk("t2_done_off", done, 1'b0);
        chk("t2_busy_off", busy, 1'b0);
        chk("t2_done_cnt", n_done, 1);
        mon_en = 1'b0;

        // Waitrequest held for 3 cycles on the second word.
        wait_mode = 2;
        avm_waitrequest = 1'b0;
        setup(32'h1000, 1);
        pulse_start();
        @(posedge clk); #1;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_read", avm_read, 1'b1);
            chk("t3_stall_addr", avm_address, 32'h1004);
            chk("t3_stall_valid", blk_valid, 1'b0);
            @(posedge clk); #1;
        end
        avm_waitrequest = 1'b0;
        chk("t3_release_addr", avm_address, 32'h1004);
        finish_xfer("t3");
        wait_mode = 0;

        // Backpressure: 6 blocks into a 4-deep FIFO, ready held low.
        salt = 32'h5A5A_0F0F;
        ready_mode = 2;
        blk_ready = 1'b0;
        setup(32'h0002_0000, 6);
        pulse_start();
        repeat (19) begin
            @(posedge clk); #1;
        end
        chk("t4_pushed", n_push, DEPTH);
        chk("t4_read_off", avm_read, 1'b0);
        chk("t4_busy", busy, 1'b1);
        ready_mode = 0;
        blk_ready = 1'b1;
        finish_xfer("t4");

        // Address wrap across the top of the address space.
        setup(32'hFFFF_FFF8, 2);
        pulse_start();
        finish_xfer("t5");

        // Reset during RD_HI of block 3 of 5, then restart elsewhere.
        setup(32'h3000, 5);
        pulse_start();
        k = 0;
        while (n_rd < 5 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t6_reached", n_rd, 5);
        mon_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_read", avm_read, 1'b0);
        chk("t6_addr", avm_address, 32'h0);
        chk("t6_valid", blk_valid, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        setup(32'h2000, 2);
        pulse_start();
        finish_xfer("t6b");

        // Random transfers with random stalls and backpressure.
        wait_mode = 1;
        ready_mode = 1;
        for (int t = 0; t < 6; t++) begin
            salt = $urandom;
            setup($urandom, 32'($urandom_range(1, 9)));
            pulse_start();
            finish_xfer("rnd");
        end
        wait_mode = 0;
        ready_mode = 0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
